uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_tick.sv | 32 +++
 rtl/uart_rx.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receive state enum, defaults and parity helper (optional: UART_RX_PARITY_EN)
package uart_pkg;

   localparam int DEFAULT_CLKS_PER_BIT = 868;
   localparam int MAX_DATA_BITS        = 9;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
`ifdef UART_RX_PARITY_EN
      RX_PARITY,
`endif
      RX_STOP,
      RX_WAIT_IDLE
   } rx_state_t;

   // Even parity bit for a word zero-extended to the widest supported frame.
   function automatic logic even_parity(input logic [MAX_DATA_BITS-1:0] word);
      return ^word;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period counter giving mid-bit and end-of-period ticks
module uart_baud_tick #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic restart,
   output logic mid_tick,
   output logic full_tick
);

   localparam int           CW   = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] count;

   // Free-running period counter; restart pins it to zero, otherwise it wraps at the period end.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         count <= '0;
      end else if (restart || count == LAST) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

   assign mid_tick  = (count == MID);
   assign full_tick = (count == LAST);

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver with valid/ready output register (optional parity: UART_RX_PARITY_EN)
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int DATA_BITS    = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_rx,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic                 o_frame_err,
   output logic                 o_overrun,
`ifdef UART_RX_PARITY_EN
   output logic                 o_parity_err,
`endif
   output logic                 o_busy
);

   localparam int            BW       = $clog2(DATA_BITS + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   rx_state_t            state;
   rx_state_t            state_next;
   logic [DATA_BITS-1:0] shreg;
   logic [BW-1:0]        bit_cnt;
   logic                 restart;
   logic                 mid_tick;
   logic                 full_tick;
   logic                 shift_en;
   logic                 bit_clr;
   logic                 word_done;
   logic                 frame_bad;
`ifdef UART_RX_PARITY_EN
   logic                 par_bit;
   logic                 par_load;
   logic                 par_bad;
   logic                 par_mismatch;

   // Data bits plus received parity bit must XOR to zero for even parity.
   assign par_mismatch = even_parity(MAX_DATA_BITS'(shreg)) ^ par_bit;
`endif

   uart_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .restart  (restart),
      .mid_tick (mid_tick),
      .full_tick(full_tick)
   );

   // State register; reset parks in WAIT_IDLE so a frame in flight is never half-decoded.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state <= RX_WAIT_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and per-cycle strobes; the FSM never waits on the consumer.
   always_comb begin
      state_next = state;
      restart    = 1'b0;
      shift_en   = 1'b0;
      bit_clr    = 1'b0;
      word_done  = 1'b0;
      frame_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_load   = 1'b0;
      par_bad    = 1'b0;
`endif
      case (state)
         RX_IDLE: begin
            restart = 1'b1;
            bit_clr = 1'b1;
            if (!i_rx) begin
               state_next = RX_START;
            end
         end
         RX_START: begin
            if (mid_tick) begin
               restart    = 1'b1;
               state_next = i_rx ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (full_tick) begin
               shift_en = 1'b1;
               if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                  state_next = RX_PARITY;
`else
                  state_next = RX_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         RX_PARITY: begin
            if (full_tick) begin
               par_load   = 1'b1;
               state_next = RX_STOP;
            end
         end
`endif
         RX_STOP: begin
            if (full_tick) begin
`ifdef UART_RX_PARITY_EN
               par_bad = par_mismatch;
`endif
               if (i_rx) begin
`ifdef UART_RX_PARITY_EN
                  word_done = !par_mismatch;
`else
                  word_done = 1'b1;
`endif
                  state_next = RX_IDLE;
               end else begin
                  frame_bad  = 1'b1;
                  state_next = RX_WAIT_IDLE;
               end
            end
         end
         RX_WAIT_IDLE: begin
            restart = 1'b1;
            if (i_rx) begin
               state_next = RX_IDLE;
            end
         end
         default: begin
            state_next = RX_WAIT_IDLE;
         end
      endcase
   end

   // Shift register (LSB arrives first, so shift right from the top) and bit counter.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         shreg   <= '0;
         bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
         par_bit <= 1'b0;
`endif
      end else begin
         if (bit_clr) begin
            bit_cnt <= '0;
         end else if (shift_en) begin
            bit_cnt <= bit_cnt + BW'(1);
         end
         if (shift_en) begin
            shreg <= {i_rx, shreg[DATA_BITS-1:1]};
         end
`ifdef UART_RX_PARITY_EN
         if (par_load) begin
            par_bit <= i_rx;
         end
`endif
      end
   end

   // Output register: a completed word loads unless the previous one is still held un-accepted.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_data      <= '0;
         o_valid     <= 1'b0;
         o_frame_err <= 1'b0;
         o_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         o_parity_err <= 1'b0;
`endif
      end else begin
         o_frame_err <= frame_bad;
         o_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         o_parity_err <= par_bad;
`endif
         if (word_done) begin
            if (o_valid && !i_ready) begin
               o_overrun <= 1'b1;
            end else begin
               o_data  <= shreg;
               o_valid <= 1'b1;
            end
         end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
         end
      end
   end

   assign o_busy = (state != RX_IDLE);

endmodule
